xor_stream_unit: RTL

- Parametrised, registered successor to the team's single-bit combinational XOR block.
- Takes a valid/ready stream of operand pairs (a, b) of WIDTH bits each and computes their XOR.
- Three modes: per-beat XOR, XOR accumulated over a packet, or per-beat reduction parity.
- Result goes out on a one-deep registered valid/ready port with a beat count. Used as the NPC's checksum/parity helper.

---
 rtl/xor_stream_unit_pkg.sv | 7 +
 rtl/xor_stream_unit_if.sv | 17 +
 rtl/xor_stream_unit_out_slot.sv | 29 ++
 rtl/xor_stream_unit.sv | 72 +++++++
 4 files changed

// File: rtl/xor_stream_unit_pkg.sv
// xor_stream_pkg: shared modes, states and default sizes for the XOR stream unit
package xor_stream_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {MODE_PAIR, MODE_ACC, MODE_PAR, MODE_RSVD} mode_e;
  typedef enum logic {S_IDLE, S_ACC} state_e;
endpackage

// File: rtl/xor_stream_unit_if.sv
// xor_stream_if: operand input stream and result output stream of the XOR unit
interface xor_stream_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic [1:0] mode;
  logic in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_a, in_b;
  logic out_valid, out_ready, out_parity, out_sat;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  modport master (
    output mode, in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_count, out_sat
  );
  modport slave (
    input  mode, in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_count, out_sat
  );
endinterface

// File: rtl/xor_stream_unit_out_slot.sv
// xor_out_slot: one-entry registered output holding slot with valid/ready handshake
module xor_out_slot #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_out_ready,
  output logic         o_in_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign o_in_ready = !r_valid || i_out_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  // a new result overwrites the slot even while it is being taken, so there is no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/xor_stream_unit.sv
// xor_stream_unit: registered per-beat XOR, packet XOR accumulation or per-beat parity
module xor_stream_unit
  import xor_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  xor_stream_if.slave bus
);
  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_acc, w_acc_d, w_x, w_res;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d, w_cnt_inc, w_res_cnt;
  logic               w_in_ready, w_accept, w_load;
  logic [CNT_W+WIDTH-1:0] w_slot;
  assign w_x       = bus.in_a ^ bus.in_b;
  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  // next-state, accumulator update and result selection for the accepted beat
  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_load    = 1'b0;
    w_res     = w_x;
    w_res_cnt = CNT_W'(1);
    if (w_accept) begin
      if (r_state == S_ACC) begin
        w_acc_d   = r_acc ^ w_x;
        w_cnt_d   = w_cnt_inc;
        w_res     = r_acc ^ w_x;
        w_res_cnt = w_cnt_inc;
        w_load    = bus.in_last;
        w_state_d = bus.in_last ? S_IDLE : S_ACC;
      end else if (mode_e'(bus.mode) == MODE_ACC && !bus.in_last) begin
        w_acc_d   = w_x;
        w_cnt_d   = CNT_W'(1);
        w_state_d = S_ACC;
      end else begin
        w_load = 1'b1;
        w_res  = (mode_e'(bus.mode) == MODE_PAR) ? WIDTH'(^w_x) : w_x;
      end
    end
  end
  // packet state register; reset discards any open packet
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
    end
  end
  xor_out_slot #(.W(CNT_W + WIDTH)) u_slot (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      ({w_res_cnt, w_res}),
    .i_out_ready (bus.out_ready),
    .o_in_ready  (w_in_ready),
    .o_valid     (bus.out_valid),
    .o_data      (w_slot)
  );
  assign bus.in_ready   = w_in_ready;
  assign {bus.out_count, bus.out_data} = w_slot;
  assign bus.out_parity = ^bus.out_data;
  assign bus.out_sat    = &bus.out_count;
endmodule
